// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//
// Control-phase sequencer for the MU0 core. It produces the one-hot
// FETCH / EXEC1 / EXEC2 phase strobes that drive the instruction decoder.
// It reads the IR opcode during EXEC1 to pick the next phase. It supports
// free-run and single-step modes and halts permanently on STP. It also keeps
// saturating debug counters for completed instructions and active cycles.
//
// Ports
//   clk        in   1      system clock, all state changes on the rising edge
//   rst_n      in   1      synchronous active-low reset
//   run        in   1      level; launches execution while the sequencer is IDLE
//   step_mode  in   1      1 = return to IDLE after every completed instruction
//   op         in   4      IR[15:12]; only looked at during EXEC1
//   fetch      out  1      fetch phase strobe
//   exec1      out  1      first execute phase strobe
//   exec2      out  1      second execute phase strobe (LDA only)
//   halted     out  1      high while in the HALT state
//   instr_cnt  out  CNT_W  completed instructions, saturating
//   cycle_cnt  out  CNT_W  cycles spent in FETCH/EXEC1/EXEC2, saturating
// ---------------------------------------------------------------------------
module cpu_sequencer #(
   parameter int          CNT_W  = 16,
   parameter logic [3:0]  LDA_OP = 4'h0,
   parameter logic [3:0]  STP_OP = 4'h7
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             step_mode,
   input  logic [3:0]       op,
   output logic             fetch,
   output logic             exec1,
   output logic             exec2,
   output logic             halted,
   output logic [CNT_W-1:0] instr_cnt,
   output logic [CNT_W-1:0] cycle_cnt
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_EXEC1 = 3'd2,
      S_EXEC2 = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   logic instr_done;
   logic phase_active;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   // State register. Reset is synchronous so it is only seen at a clock edge,
   // and it wins over any transition, including one that would complete an
   // instruction in EXEC2.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus the two events the counters care about.
   // An instruction completes on the EXEC1 exit of every non-LDA opcode (STP
   // included) and on every EXEC2 exit. Where it goes afterwards depends on
   // step_mode as sampled at that completing edge, so free-run mode has no
   // bubble between instructions.
   always_comb begin
      next_state   = state;
      instr_done   = 1'b0;
      phase_active = 1'b0;

      case (state)
         S_IDLE: begin
            if (run) begin
               next_state = S_FETCH;
            end
         end

         S_FETCH: begin
            phase_active = 1'b1;
            next_state   = S_EXEC1;
         end

         S_EXEC1: begin
            phase_active = 1'b1;
            if (op == STP_OP) begin
               instr_done = 1'b1;
               next_state = S_HALT;
            end else if (op == LDA_OP) begin
               next_state = S_EXEC2;
            end else begin
               instr_done = 1'b1;
               next_state = step_mode ? S_IDLE : S_FETCH;
            end
         end

         S_EXEC2: begin
            phase_active = 1'b1;
            instr_done   = 1'b1;
            next_state   = step_mode ? S_IDLE : S_FETCH;
         end

         S_HALT: begin
            next_state = S_HALT;
         end

         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Completed-instruction counter. It sticks at all-ones instead of wrapping,
   // so a long debug run never looks like a short one.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instr_cnt <= '0;
      end else if (instr_done && (instr_cnt != CNT_MAX)) begin
         instr_cnt <= instr_cnt + CNT_ONE;
      end
   end

   // Active-cycle counter. It counts every edge taken while in a phase state,
   // and also sticks at all-ones.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycle_cnt <= '0;
      end else if (phase_active && (cycle_cnt != CNT_MAX)) begin
         cycle_cnt <= cycle_cnt + CNT_ONE;
      end
   end

   // The strobes are decoded straight from the registered state, so they are
   // one-hot and glitch-free relative to the clock. All of them are zero in
   // IDLE and HALT.
   always_comb begin
      fetch  = (state == S_FETCH);
      exec1  = (state == S_EXEC1);
      exec2  = (state == S_EXEC2);
      halted = (state == S_HALT);
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Testbench for cpu_sequencer. Unit 0 is a default instance (CNT_W=16).
// Unit 1 uses CNT_W=2 to exercise counter saturation. Every stimulus cycle
// pushes its expected post-edge outputs onto a scoreboard queue. The entry is
// popped and compared #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

   localparam int ST_I  = 0;
   localparam int ST_F  = 1;
   localparam int ST_E1 = 2;
   localparam int ST_E2 = 3;
   localparam int ST_H  = 4;

   logic        clk;
   logic        rst_n0, run0, step0;
   logic [3:0]  op0;
   logic        fetch0, exec10, exec20, halted0;
   logic [15:0] instr_cnt0, cycle_cnt0;

   logic        rst_n1, run1, step1;
   logic [3:0]  op1;
   logic        fetch1, exec11, exec21, halted1;
   logic [1:0]  instr_cnt1, cycle_cnt1;

   typedef struct {
      logic       rst_n;
      logic       run;
      logic       step;
      logic [3:0] op;
      int         st;
      int         ic;
      int         cc;
   } vec_t;

   typedef struct {
      string      tag;
      int         unit;
      int         st;
      logic [31:0] ic;
      logic [31:0] cc;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];

   int checks = 0;
   int errors = 0;

   cpu_sequencer dut0 (
      .clk       (clk),
      .rst_n     (rst_n0),
      .run       (run0),
      .step_mode (step0),
      .op        (op0),
      .fetch     (fetch0),
      .exec1     (exec10),
      .exec2     (exec20),
      .halted    (halted0),
      .instr_cnt (instr_cnt0),
      .cycle_cnt (cycle_cnt0)
   );

   cpu_sequencer #(.CNT_W(2)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n1),
      .run       (run1),
      .step_mode (step1),
      .op        (op1),
      .fetch     (fetch1),
      .exec1     (exec11),
      .exec2     (exec21),
      .halted    (halted1),
      .instr_cnt (instr_cnt1),
      .cycle_cnt (cycle_cnt1)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mkVec(logic r, logic rn, logic s, logic [3:0] o,
                                  int st, int ic, int cc);
      vec_t v;
      v.rst_n = r;
      v.run   = rn;
      v.step  = s;
      v.op    = o;
      v.st    = st;
      v.ic    = ic;
      v.cc    = cc;
      return v;
   endfunction

   // Turns an expected state code into the strobe pattern {fetch,exec1,exec2,halted}.
   function automatic logic [3:0] strobesOf(int st);
      case (st)
         ST_F:    return 4'b1000;
         ST_E1:   return 4'b0100;
         ST_E2:   return 4'b0010;
         ST_H:    return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   // Pops the oldest expectation and compares it with the selected unit.
   task automatic checkOutput();
      exp_t        e;
      logic [3:0]  got_s;
      logic [31:0] got_ic, got_cc;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard: got empty queue, required an expectation");
         return;
      end
      e = sb.pop_front();
      if (e.unit == 0) begin
         got_s  = {fetch0, exec10, exec20, halted0};
         got_ic = {16'b0, instr_cnt0};
         got_cc = {16'b0, cycle_cnt0};
      end else begin
         got_s  = {fetch1, exec11, exec21, halted1};
         got_ic = {30'b0, instr_cnt1};
         got_cc = {30'b0, cycle_cnt1};
      end
      if (got_s !== strobesOf(e.st) || got_ic !== e.ic || got_cc !== e.cc) begin
         errors++;
         $display("[TB] FAIL %s: got strobes=%b instr=%0d cycle=%0d, required strobes=%b instr=%0d cycle=%0d",
                  e.tag, got_s, got_ic, got_cc, strobesOf(e.st), e.ic, e.cc);
      end
   endtask

   // Drives one cycle of stimulus, records what should appear after the edge,
   // then samples 1 ns past the edge.
   task automatic applyStimulus(input int unit, input string tag,
                                input logic r, input logic rn, input logic s,
                                input logic [3:0] o,
                                input int st, input int ic, input int cc);
      exp_t e;
      if (unit == 0) begin
         rst_n0 = r; run0 = rn; step0 = s; op0 = o;
      end else begin
         rst_n1 = r; run1 = rn; step1 = s; op1 = o;
      end
      e.tag  = tag;
      e.unit = unit;
      e.st   = st;
      e.ic   = 32'(ic);
      e.cc   = 32'(cc);
      sb.push_back(e);
      @(posedge clk);
      #1;
      checkOutput();
   endtask

   initial begin
      rst_n0 = 1'b0; run0 = 1'b0; step0 = 1'b0; op0 = 4'h0;
      rst_n1 = 1'b0; run1 = 1'b0; step1 = 1'b0; op1 = 4'h0;

      // Free-run ADD: 3 instructions in 6 cycles.
      tbl.push_back(mkVec(0, 0, 0, 4'h2, ST_I,  0, 0));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_F,  0, 0));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_E1, 0, 1));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_F,  1, 2));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_E1, 1, 3));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_F,  2, 4));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_E1, 2, 5));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_F,  3, 6));
      // Free-run LDA: 2 instructions in 6 cycles.
      tbl.push_back(mkVec(0, 1, 0, 4'h0, ST_I,  0, 0));
      tbl.push_back(mkVec(1, 1, 0, 4'h0, ST_F,  0, 0));
      tbl.push_back(mkVec(1, 1, 0, 4'h0, ST_E1, 0, 1));
      tbl.push_back(mkVec(1, 1, 0, 4'h0, ST_E2, 0, 2));
      tbl.push_back(mkVec(1, 1, 0, 4'h0, ST_F,  1, 3));
      tbl.push_back(mkVec(1, 1, 0, 4'h0, ST_E1, 1, 4));
      tbl.push_back(mkVec(1, 1, 0, 4'h0, ST_E2, 1, 5));
      tbl.push_back(mkVec(1, 1, 0, 4'h0, ST_F,  2, 6));
      // ADD, then STP. The STP opcode seen during FETCH is ignored.
      tbl.push_back(mkVec(0, 0, 0, 4'h2, ST_I,  0, 0));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_F,  0, 0));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_E1, 0, 1));
      tbl.push_back(mkVec(1, 1, 0, 4'h2, ST_F,  1, 2));
      tbl.push_back(mkVec(1, 1, 0, 4'h7, ST_E1, 1, 3));
      tbl.push_back(mkVec(1, 1, 0, 4'h7, ST_H,  2, 4));

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(0, $sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].run,
                       tbl[i].step, tbl[i].op, tbl[i].st, tbl[i].ic, tbl[i].cc);
      end

      // HALT ignores run, step_mode and op for 10 cycles.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, $sformatf("halt_hold%0d", i), 1'b1, 1'(i % 2),
                       1'(i / 5), 4'($urandom_range(0, 15)), ST_H, 2, 4);
      end

      // Step mode with a single RUN pulse on LDA, then stays idle.
      applyStimulus(0, "step_rst",    0, 0, 1, 4'h0, ST_I,  0, 0);
      applyStimulus(0, "step_launch", 1, 1, 1, 4'h0, ST_F,  0, 0);
      applyStimulus(0, "step_e1",     1, 0, 1, 4'h0, ST_E1, 0, 1);
      applyStimulus(0, "step_e2",     1, 0, 1, 4'h0, ST_E2, 0, 2);
      applyStimulus(0, "step_done",   1, 0, 1, 4'h0, ST_I,  1, 3);
      applyStimulus(0, "step_idle0",  1, 0, 1, 4'h2, ST_I,  1, 3);
      applyStimulus(0, "step_idle1",  1, 0, 1, 4'h7, ST_I,  1, 3);
      // Held RUN relaunches straight after the return to IDLE. step_mode is
      // sampled only at the completing edge, and 4'hB/4'hF are single-phase.
      applyStimulus(0, "hold_f",      1, 1, 1, 4'h2, ST_F,  1, 3);
      applyStimulus(0, "hold_e1",     1, 1, 1, 4'h2, ST_E1, 1, 4);
      applyStimulus(0, "hold_done",   1, 1, 1, 4'h2, ST_I,  2, 5);
      applyStimulus(0, "hold_relnch", 1, 1, 1, 4'h2, ST_F,  2, 5);
      applyStimulus(0, "opb_e1",      1, 0, 1, 4'hB, ST_E1, 2, 6);
      applyStimulus(0, "opb_free",    1, 0, 0, 4'hB, ST_F,  3, 7);
      applyStimulus(0, "opf_e1",      1, 0, 1, 4'hF, ST_E1, 3, 8);
      applyStimulus(0, "opf_step",    1, 0, 1, 4'hF, ST_I,  4, 9);

      // Reset taken in the middle of EXEC2 completes nothing.
      applyStimulus(0, "mid_f",       1, 1, 0, 4'h0, ST_F,  4, 9);
      applyStimulus(0, "mid_e1",      1, 1, 0, 4'h0, ST_E1, 4, 10);
      applyStimulus(0, "mid_e2",      1, 1, 0, 4'h0, ST_E2, 4, 11);
      applyStimulus(0, "mid_reset",   0, 1, 0, 4'h0, ST_I,  0, 0);
      applyStimulus(0, "post_reset",  1, 0, 0, 4'h0, ST_I,  0, 0);

      // CNT_W=2 unit: 5 ADDs in free run. Both counters saturate at 3.
      applyStimulus(1, "sat_rst", 0, 0, 0, 4'h2, ST_I, 0, 0);
      applyStimulus(1, "sat_c0",  1, 1, 0, 4'h2, ST_F, 0, 0);
      for (int c = 1; c <= 10; c++) begin
         applyStimulus(1, $sformatf("sat_c%0d", c), 1, 1, 0, 4'h2,
                       (c % 2 == 1) ? ST_E1 : ST_F,
                       (c / 2 > 3) ? 3 : c / 2,
                       (c > 3) ? 3 : c);
      end

      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
